// File: rtl/wb_scheduler.sv
// wb_scheduler: tracks in-flight instructions from issue to register-file
// writeback. Books the single write port with a reservation shift vector,
// keeps a per-register pending bitmap for RAW/WAW checks, and stalls issue
// on write-port conflicts, a busy non-pipelined multiplier, or WAW hazards.
module wb_scheduler #(
  parameter int LAT_ALU = 1,  // pipelined ALU latency
  parameter int LAT_MEM = 2,  // pipelined MEM latency
  parameter int LAT_MUL = 4,  // non-pipelined MUL latency
  parameter int MAXLAT  = 4   // reservation depth, >= every LAT_*
) (
  input  logic        clock,
  input  logic        reset,            // asynchronous, active-low
  input  logic        is_sch_valid,
  input  logic [1:0]  is_sch_fununit,
  input  logic [4:0]  is_sch_regdest,
  input  logic        is_sch_writereg,
  output logic        sch_is_stall,
  output logic [31:0] sch_is_pending,
  output logic        sch_wb_valid,
  output logic [4:0]  sch_wb_regdest,
  output logic [1:0]  sch_wb_fununit
);

  localparam int LW = $clog2(MAXLAT + 1);
  localparam int CW = $clog2(LAT_MUL + 1);

  // Slot j holds a writeback booked j cycles from now; slot 0 feeds the outputs.
  logic [MAXLAT:0]       slot_v_q, slot_v_d;
  logic [MAXLAT:0][4:0]  slot_rd_q, slot_rd_d;
  logic [MAXLAT:0][1:0]  slot_fu_q, slot_fu_d;
  logic [CW-1:0]         mul_cnt_q, mul_cnt_d;
  logic [31:0]           pending_q, pending_d;

  logic [LW-1:0] lat_s;
  logic [LW-1:0] tgt_s;
  logic          wr_s;
  logic          port_conflict_s;
  logic          mul_busy_s;
  logic          waw_s;
  logic          accept_s;

  // Hazard detection and issue acceptance for the presented instruction.
  always_comb begin
    case (is_sch_fununit)
      2'b01:   lat_s = LW'(LAT_ALU);
      2'b10:   lat_s = LW'(LAT_MEM);
      2'b11:   lat_s = LW'(LAT_MUL);
      default: lat_s = LW'(1);
    endcase
    tgt_s           = lat_s - LW'(1);
    wr_s            = is_sch_writereg && (is_sch_regdest != 5'd0);
    port_conflict_s = wr_s && slot_v_q[lat_s];
    mul_busy_s      = (is_sch_fununit == 2'b11) && (mul_cnt_q > CW'(1));
    waw_s           = wr_s && pending_q[is_sch_regdest];
    sch_is_stall    = is_sch_valid && (is_sch_fununit != 2'b00) &&
                      (port_conflict_s || mul_busy_s || waw_s);
    accept_s        = is_sch_valid && (is_sch_fununit != 2'b00) && !sch_is_stall;
  end

  // Next state: shift reservations, book the new writeback, update MUL
  // occupancy and the pending bitmap (set beats clear on the same bit).
  always_comb begin
    slot_v_d  = '0;
    slot_rd_d = '0;
    slot_fu_d = '0;
    for (int j = 0; j < MAXLAT; j++) begin
      slot_v_d[j]  = slot_v_q[j+1];
      slot_rd_d[j] = slot_rd_q[j+1];
      slot_fu_d[j] = slot_fu_q[j+1];
    end
    if (accept_s && wr_s) begin
      slot_v_d[tgt_s]  = 1'b1;
      slot_rd_d[tgt_s] = is_sch_regdest;
      slot_fu_d[tgt_s] = is_sch_fununit;
    end else begin
      slot_v_d[MAXLAT] = 1'b0;
    end

    if (accept_s && (is_sch_fununit == 2'b11)) begin
      mul_cnt_d = CW'(LAT_MUL);
    end else if (mul_cnt_q != CW'(0)) begin
      mul_cnt_d = mul_cnt_q - CW'(1);
    end else begin
      mul_cnt_d = mul_cnt_q;
    end

    pending_d = pending_q;
    if (slot_v_q[0]) begin
      pending_d[slot_rd_q[0]] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (accept_s && wr_s) begin
      pending_d[is_sch_regdest] = 1'b1;
    end else begin
      pending_d[0] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset discards every in-flight operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_v_q  <= '0;
      slot_rd_q <= '0;
      slot_fu_q <= '0;
      mul_cnt_q <= '0;
      pending_q <= '0;
    end else begin
      slot_v_q  <= slot_v_d;
      slot_rd_q <= slot_rd_d;
      slot_fu_q <= slot_fu_d;
      mul_cnt_q <= mul_cnt_d;
      pending_q <= pending_d;
    end
  end

  assign sch_wb_valid   = slot_v_q[0];
  assign sch_wb_regdest = slot_rd_q[0];
  assign sch_wb_fununit = slot_fu_q[0];
  assign sch_is_pending = pending_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Self-checking bench for wb_scheduler: table-driven per-cycle vectors plus
// a writeback scoreboard, and a hand-written mid-flight reset sequence.
module tb_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        is_sch_valid = 1'b0;
  logic [1:0]  is_sch_fununit = 2'b00;
  logic [4:0]  is_sch_regdest = 5'd0;
  logic        is_sch_writereg = 1'b0;
  logic        sch_is_stall;
  logic [31:0] sch_is_pending;
  logic        sch_wb_valid;
  logic [4:0]  sch_wb_regdest;
  logic [1:0]  sch_wb_fununit;

  wb_scheduler dut (
    .clock(clock), .reset(reset),
    .is_sch_valid(is_sch_valid), .is_sch_fununit(is_sch_fununit),
    .is_sch_regdest(is_sch_regdest), .is_sch_writereg(is_sch_writereg),
    .sch_is_stall(sch_is_stall), .sch_is_pending(sch_is_pending),
    .sch_wb_valid(sch_wb_valid), .sch_wb_regdest(sch_wb_regdest),
    .sch_wb_fununit(sch_wb_fununit)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rs;      // apply reset before this row (cycle restarts at 0)
    bit          v;
    logic [1:0]  fu;
    logic [4:0]  rd;
    bit          wr;
    bit          st;      // expected stall
    logic [31:0] pend;    // expected pending bitmap
  } vec_t;

  typedef struct {
    int         cyc;
    logic [4:0] rd;
    logic [1:0] fu;
  } wb_t;

  vec_t vecs[$];
  wb_t  sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  function automatic int lat_of(input logic [1:0] fu);
    case (fu)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic void add(input bit rs, input bit v, input logic [1:0] fu,
                              input logic [4:0] rd, input bit wr, input bit st,
                              input logic [31:0] pend);
    vec_t e;
    e.rs = rs; e.v = v; e.fu = fu; e.rd = rd; e.wr = wr; e.st = st; e.pend = pend;
    vecs.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare this cycle's writeback outputs with the scoreboard front.
  task automatic check_wb();
    bit exp_v;
    exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
    chk("wb_valid", 32'(sch_wb_valid), 32'(exp_v));
    if (exp_v) begin
      chk("wb_regdest", 32'(sch_wb_regdest), 32'(sb[0].rd));
      chk("wb_fununit", 32'(sch_wb_fununit), 32'(sb[0].fu));
      void'(sb.pop_front());
    end else begin
      chk("wb_regdest_idle", 32'(sch_wb_regdest), 32'd0);
      chk("wb_fununit_idle", 32'(sch_wb_fununit), 32'd0);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] fu, input logic [4:0] rd, input bit wr);
    is_sch_valid = v; is_sch_fununit = fu; is_sch_regdest = rd; is_sch_writereg = wr;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'b00, 5'd0, 1'b0);
    reset = 1'b0;
    sb.delete();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pending", sch_is_pending, 32'd0);
    chk("rst_wb_valid", 32'(sch_wb_valid), 32'd0);
    chk("rst_stall", 32'(sch_is_stall), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cyc = 0;
  endtask

  // One cycle: inputs driven just after the edge, outputs checked at negedge.
  task automatic step(input vec_t e);
    drive(e.v, e.fu, e.rd, e.wr);
    @(negedge clock);
    chk("stall", 32'(sch_is_stall), 32'(e.st));
    chk("pending", sch_is_pending, e.pend);
    check_wb();
    if (e.v && e.fu != 2'b00 && !e.st && e.wr && e.rd != 5'd0) begin
      wb_t w;
      w.cyc = cyc + lat_of(e.fu); w.rd = e.rd; w.fu = e.fu;
      sb.push_back(w);
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    // 1: ALU rd5
    add(1, 1, 2'b01, 5'd5, 1, 0, 32'h0);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h20);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h0);
    // 2: MUL rd3, MEM rd4 hits port conflict in cycle 2
    add(1, 1, 2'b11, 5'd3, 1, 0, 32'h0);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h8);
    add(0, 1, 2'b10, 5'd4, 1, 1, 32'h8);
    add(0, 1, 2'b10, 5'd4, 1, 0, 32'h8);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h18);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h10);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h0);
    // 3: back-to-back MUL
    add(1, 1, 2'b11, 5'd1, 1, 0, 32'h0);
    add(0, 1, 2'b11, 5'd2, 1, 1, 32'h2);
    add(0, 1, 2'b11, 5'd2, 1, 1, 32'h2);
    add(0, 1, 2'b11, 5'd2, 1, 1, 32'h2);
    add(0, 1, 2'b11, 5'd2, 1, 0, 32'h2);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h4);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h4);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h4);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h4);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h0);
    // 4: WAW on rd7
    add(1, 1, 2'b11, 5'd7, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) add(0, 1, 2'b01, 5'd7, 1, 1, 32'h80);
    add(0, 1, 2'b01, 5'd7, 1, 0, 32'h0);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h80);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h0);
    // 5: non-writing ops, bubble, and MUL occupancy without a slot
    add(1, 1, 2'b11, 5'd6, 1, 0, 32'h0);
    add(0, 1, 2'b01, 5'd8, 0, 0, 32'h40);
    add(0, 1, 2'b01, 5'd0, 1, 0, 32'h40);
    add(0, 1, 2'b10, 5'd10, 0, 0, 32'h40);
    add(0, 1, 2'b00, 5'd6, 1, 0, 32'h40);
    add(0, 1, 2'b11, 5'd0, 1, 0, 32'h0);
    add(0, 1, 2'b11, 5'd11, 1, 1, 32'h0);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h0);
    add(0, 0, 2'b00, 5'd0, 0, 0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rs) do_reset();
      step(vecs[i]);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // 6: reset asserted while MEM rd9 is in flight
    do_reset();
    begin
      vec_t e;
      e.rs = 0; e.v = 1; e.fu = 2'b10; e.rd = 5'd9; e.wr = 1; e.st = 0; e.pend = 32'h0;
      step(e);
    end
    drive(1'b0, 2'b00, 5'd0, 1'b0);
    chk("pre_rst_pending", sch_is_pending, 32'h200);
    reset = 1'b0;
    #1;
    chk("midrst_pending", sch_is_pending, 32'd0);
    chk("midrst_wb_valid", 32'(sch_wb_valid), 32'd0);
    chk("midrst_wb_regdest", 32'(sch_wb_regdest), 32'd0);
    chk("midrst_wb_fununit", 32'(sch_wb_fununit), 32'd0);
    chk("midrst_stall", 32'(sch_is_stall), 32'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    cyc = 0;
    begin
      vec_t e;
      e.rs = 0; e.v = 0; e.fu = 2'b00; e.rd = 5'd0; e.wr = 0; e.st = 0; e.pend = 32'h0;
      for (int i = 0; i < 3; i++) step(e);
      e.v = 1; e.fu = 2'b01; e.rd = 5'd9; e.wr = 1;
      step(e);
      e.v = 0; e.fu = 2'b00; e.rd = 5'd0; e.wr = 0; e.pend = 32'h200;
      step(e);
      e.pend = 32'h0;
      step(e);
    end
    chk("sb_drained_rst", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
